// File: rtl/ppu_stream_gen.sv
// ppu_stream_gen: Game Boy LCD-timed pixel stream (vs/hs/de/color) that zero-fills a line when upstream
// pixels cannot arrive in time, so every visible line carries exactly WIDTH de pulses.
module ppu_stream_gen #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 144,
    parameter int H_TOTAL  = 456,
    parameter int V_TOTAL  = 154,
    parameter int OAM_DOTS = 80
) (
    input  logic       tclk,
    input  logic       rst,
    input  logic       ce,
    input  logic       lcd_en,
    input  logic       pix_valid,
    input  logic [1:0] pix_data,
    output logic       pix_ready,
    output logic       vs,
    output logic       hs,
    output logic       de,
    output logic [1:0] color,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       underrun
);
    typedef enum logic [2:0] {S_OAM, S_DRAW, S_FILL, S_HBLANK, S_VBLANK} state_t;
    state_t     state, state_n;
    logic [8:0] dot;
    logic [7:0] line, line_nx, px_cnt;
    logic [1:0] mode_n;
    logic       adv, dot_last, line_last, px_last, draw_open, deadline, xfer, fill;

    assign adv       = lcd_en & ce;
    assign dot_last  = dot == 9'(H_TOTAL - 1);
    assign line_last = line == 8'(V_TOTAL - 1);
    assign line_nx   = line_last ? 8'd0 : line + 8'd1;
    assign px_last   = px_cnt == 8'(WIDTH - 1);
    assign draw_open = (state == S_DRAW) & (px_cnt < 8'(WIDTH));
    // Remaining dots equal remaining pixels: from here on every dot must emit a pixel.
    assign deadline  = (10'(H_TOTAL - 1) - 10'(dot)) == (10'(WIDTH) - 10'(px_cnt));
    assign pix_ready = adv & draw_open & ~deadline;
    assign xfer      = pix_valid & pix_ready;
    assign fill      = adv & ((draw_open & deadline) | (state == S_FILL));

    always_comb begin
        state_n = state;
        mode_n  = state == S_OAM ? 2'd2 : state == S_HBLANK ? 2'd0 : state == S_VBLANK ? 2'd1 : 2'd3;
        if (adv) begin
            unique case (state)
                S_OAM:    if (dot == 9'(OAM_DOTS - 1)) state_n = S_DRAW;
                S_DRAW:   state_n = ((xfer | fill) & px_last) ? S_HBLANK : fill ? S_FILL : S_DRAW;
                S_FILL:   if (px_last) state_n = S_HBLANK;
                S_HBLANK: if (dot_last) state_n = (line_nx < 8'(HEIGHT)) ? S_OAM : S_VBLANK;
                S_VBLANK: if (dot_last & line_last) state_n = S_OAM;
                default:  state_n = S_OAM;
            endcase
        end
    end

    always_ff @(posedge tclk) begin
        if (rst || !lcd_en) begin
            state    <= S_OAM;
            dot      <= '0;
            line     <= '0;
            px_cnt   <= '0;
            vs       <= 1'b0;
            hs       <= 1'b0;
            de       <= 1'b0;
            color    <= 2'd0;
            ly       <= '0;
            mode     <= rst ? 2'd2 : 2'd0;
            underrun <= 1'b0;
        end else begin
            state <= state_n;
            vs    <= ce & (line == 8'd0) & (dot == 9'd0);
            hs    <= ce & dot_last;
            de    <= xfer | fill;
            ly    <= line;
            mode  <= mode_n;
            if (xfer) color <= pix_data;
            else if (fill) color <= 2'd0;
            if (fill) underrun <= 1'b1;
            if (ce) begin
                dot    <= dot_last ? 9'd0 : dot + 9'd1;
                line   <= dot_last ? line_nx : line;
                px_cnt <= dot_last ? 8'd0 : px_cnt + 8'(xfer | fill);
            end
        end
    end
endmodule

// File: tb/tb_ppu_stream_gen.sv
// tb_ppu_stream_gen: directed checks of line/frame timing, underrun zero-fill, ce gating
// and restart after lcd_en drop or reset.
module tb_ppu_stream_gen;
    logic       tclk = 1'b0;
    logic       rst = 1'b1, ce = 1'b0, lcd_en = 1'b1, pix_valid = 1'b0;
    logic [1:0] pix_data = 2'd0;
    logic       pix_ready, vs, hs, de, underrun;
    logic [1:0] color, mode;
    logic [7:0] ly;
    int vectors = 0, miscompares = 0;
    int n_vs = 0, n_hs = 0, n_de = 0, n_vb = 0, n_rdy_vb = 0;

    ppu_stream_gen dut (
        .tclk(tclk), .rst(rst), .ce(ce), .lcd_en(lcd_en),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .vs(vs), .hs(hs), .de(de), .color(color), .ly(ly), .mode(mode), .underrun(underrun)
    );

    always #5 tclk = ~tclk;

    task automatic tick();
        @(posedge tclk);
        #1;
        if (vs) n_vs++;
        if (hs) n_hs++;
        if (de) n_de++;
        if (mode == 2'd1) begin
            n_vb++;
            if (pix_ready) n_rdy_vb++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] strb();
        return {27'd0, vs, hs, de, de ? color : 2'd0};
    endfunction

    function automatic logic [31:0] pk_s(input logic v, input logic h, input logic d, input logic [1:0] c);
        return {27'd0, v, h, d, d ? c : 2'd0};
    endfunction

    function automatic logic [31:0] stat();
        return {21'd0, mode, ly, underrun};
    endfunction

    function automatic logic [31:0] pk_t(input logic [1:0] m, input logic [7:0] l, input logic u);
        return {21'd0, m, l, u};
    endfunction

    // Line 0 from a fresh start with a pixel offered every dot; pixel n carries shade n%4.
    task automatic run_line0(input string tag);
        rst = 1'b0;
        lcd_en = 1'b1;
        ce = 1'b1;
        pix_valid = 1'b1;
        for (int c = 1; c <= 457; c++) begin
            pix_data = 2'(c - 1);
            tick();
            check({tag, "_strb"}, strb(), pk_s(c == 1, c == 456, c >= 81 && c <= 240, 2'(c - 1)));
            check({tag, "_stat"}, stat(), pk_t(c <= 80 ? 2'd2 : c <= 240 ? 2'd3 : c <= 456 ? 2'd0 : 2'd2,
                                               c == 457 ? 8'd1 : 8'd0, 1'b0));
        end
    endtask

    task automatic hold(input string tag, input logic [1:0] m);
        for (int i = 0; i < 10; i++) begin
            tick();
            check({tag, "_strb"}, strb(), 32'd0);
            check({tag, "_stat"}, stat(), pk_t(m, 8'd0, 1'b0));
            check({tag, "_color"}, 32'(color), 32'd0);
            check({tag, "_rdy"}, 32'(pix_ready), 32'd0);
        end
    endtask

    initial begin
        ce = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_strb", strb(), 32'd0);
        check("rst_stat", stat(), pk_t(2'd2, 8'd0, 1'b0));
        check("rst_color", 32'(color), 32'd0);

        n_vs = 0; n_hs = 0; n_de = 0; n_vb = 0; n_rdy_vb = 0;
        run_line0("line0");
        for (int c = 458; c <= 70224; c++) begin
            pix_data = 2'(c - 1);
            tick();
            if ((c - 1) % 456 == 0) check("ly_seq", 32'(ly), 32'((c - 1) / 456));
        end
        check("frame_vs", n_vs, 1);
        check("frame_hs", n_hs, 154);
        check("frame_de", n_de, 144 * 160);
        check("frame_vblank_dots", n_vb, 10 * 456);
        check("frame_rdy_vblank", n_rdy_vb, 0);
        check("frame_underrun", 32'(underrun), 32'd0);
        tick();
        check("wrap_strb", strb(), pk_s(1'b1, 1'b0, 1'b0, 2'd0));
        check("wrap_stat", stat(), pk_t(2'd2, 8'd0, 1'b0));

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 1824; c++) begin
            int d, ln, r, last;
            logic e_de;
            logic [1:0] e_col;
            d = (c - 1) % 456;
            ln = (c - 1) / 456;
            r = d + 1;
            last = ln == 0 ? 454 : ln == 3 ? 398 : 239;
            pix_valid = ln == 0 ? 1'b0 : ln == 3 ? (d % 2 == 0) : 1'b1;
            pix_data = ln == 3 ? 2'(d / 2) : 2'(d);
            if (d == 0) n_de = 0;
            tick();
            e_de = ln == 0 ? (d >= 295 && d <= 454) : ln == 3 ? (d >= 80 && d <= 398 && d % 2 == 0)
                                                                : (d >= 80 && d <= 239);
            e_col = ln == 0 ? 2'd0 : ln == 3 ? 2'(d / 2) : 2'(d);
            check("fill_strb", strb(), pk_s(c == 1, d == 455, e_de, e_col));
            check("fill_stat", stat(), pk_t(r <= 80 ? 2'd2 : r <= last + 1 ? 2'd3 : 2'd0, 8'(ln),
                                            ln > 0 || d >= 295));
            if (d == 455) check("de_per_line", n_de, 160);
        end

        pix_valid = 1'b1;
        for (int c = 1825; c <= 4760; c++) tick();
        lcd_en = 1'b0;
        hold("lcd_off", 2'd0);
        run_line0("lcd_on");
        for (int c = 458; c <= 4760; c++) tick();
        rst = 1'b1;
        hold("rst_mid", 2'd2);
        run_line0("rst_rel");

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vs = 0; n_hs = 0; n_de = 0;
        for (int t = 0; t < 1828; t++) begin
            int d;
            logic c1;
            c1 = (t % 4 == 0);
            d = t / 4;
            ce = c1;
            pix_data = 2'(d);
            #1;
            if (!c1) check("rdy_no_ce", 32'(pix_ready), 32'd0);
            if (c1 && d >= 80 && d <= 239) check("rdy_draw", 32'(pix_ready), 32'd1);
            tick();
            check("ce_strb", strb(), pk_s(c1 && d == 0, c1 && d == 455, c1 && d >= 80 && d <= 239, 2'(d)));
            if (t == 1820) check("ce_ly_hold", 32'(ly), 32'd0);
            if (t == 1821) check("ce_ly_step", 32'(ly), 32'd1);
        end
        check("ce_line_de", n_de, 160);
        check("ce_line_hs", n_hs, 1);
        check("ce_line_vs", n_vs, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
